// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding and
// load-use hazard detection.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   stall, flush          hold EX contents / kill the instruction entering EX
//   idValid, id*          decoded instruction presented by the ID stage
//   memRegWrite/WriteReg/AluRes  EX/MEM forwarding source (highest priority)
//   wbRegWrite/WriteReg/Data     MEM/WB forwarding source
//   input1, input2        forwarded ALU operands
//   aluCtr, exWriteReg    ALU op code and resolved destination register
//   exValid, ex*          valid flag and valid-gated control bits
//   exStoreData           forwarded rt value for stores
//   loadUseStall          freeze IF/ID and PC this cycle
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        idValid,
  input  logic [31:0] idRsData,
  input  logic [31:0] idRtData,
  input  logic [31:0] idImm,
  input  logic [4:0]  idRs,
  input  logic [4:0]  idRt,
  input  logic [4:0]  idRd,
  input  logic [3:0]  idAluCtr,
  input  logic        idAluSrc,
  input  logic        idRegDst,
  input  logic        idRegWrite,
  input  logic        idMemRead,
  input  logic        idMemWrite,
  input  logic        idMemToReg,
  input  logic        memRegWrite,
  input  logic [4:0]  memWriteReg,
  input  logic [31:0] memAluRes,
  input  logic        wbRegWrite,
  input  logic [4:0]  wbWriteReg,
  input  logic [31:0] wbData,
  output logic [31:0] input1,
  output logic [31:0] input2,
  output logic [3:0]  aluCtr,
  output logic        exValid,
  output logic [4:0]  exWriteReg,
  output logic        exRegWrite,
  output logic        exMemRead,
  output logic        exMemWrite,
  output logic        exMemToReg,
  output logic [31:0] exStoreData,
  output logic        loadUseStall
);

  logic        valid;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] imm;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  write_reg;
  logic [3:0]  alu_ctr;
  logic        alu_src;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;

  logic [31:0] fwd_a;
  logic [31:0] fwd_b;

  // EX/MEM is the younger producer, so it is checked first; r0 is never forwarded.
  always_comb begin
    fwd_a = rs_data;
    if (memRegWrite && (memWriteReg == rs) && (rs != '0))
      fwd_a = memAluRes;
    else if (wbRegWrite && (wbWriteReg == rs) && (rs != '0))
      fwd_a = wbData;
  end

  always_comb begin
    fwd_b = rt_data;
    if (memRegWrite && (memWriteReg == rt) && (rt != '0))
      fwd_b = memAluRes;
    else if (wbRegWrite && (wbWriteReg == rt) && (rt != '0))
      fwd_b = wbData;
  end

  assign input1      = fwd_a;
  assign input2      = alu_src ? imm : fwd_b;
  assign exStoreData = fwd_b;
  assign aluCtr      = alu_ctr;
  assign exWriteReg  = write_reg;
  assign exValid     = valid;
  assign exRegWrite  = reg_write  & valid;
  assign exMemRead   = mem_read   & valid;
  assign exMemWrite  = mem_write  & valid;
  assign exMemToReg  = mem_to_reg & valid;

  assign loadUseStall = valid && mem_read && (write_reg != '0) && idValid &&
                        ((write_reg == idRs) || (write_reg == idRt));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid      <= 1'b0;
      rs_data    <= '0;
      rt_data    <= '0;
      imm        <= '0;
      rs         <= '0;
      rt         <= '0;
      write_reg  <= '0;
      alu_ctr    <= '0;
      alu_src    <= 1'b0;
      reg_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_to_reg <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (stall) begin
      // Latch forwarded operands so a producer retiring during the hold is not lost.
      rs_data <= fwd_a;
      rt_data <= fwd_b;
    end else if (loadUseStall) begin
      valid <= 1'b0;
    end else begin
      valid      <= idValid;
      rs_data    <= idRsData;
      rt_data    <= idRtData;
      imm        <= idImm;
      rs         <= idRs;
      rt         <= idRt;
      write_reg  <= idRegDst ? idRd : idRt;
      alu_ctr    <= idAluCtr;
      alu_src    <= idAluSrc;
      reg_write  <= idRegWrite;
      mem_read   <= idMemRead;
      mem_write  <= idMemWrite;
      mem_to_reg <= idMemToReg;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, idValid;
  logic [31:0] idRsData, idRtData, idImm;
  logic [4:0]  idRs, idRt, idRd;
  logic [3:0]  idAluCtr;
  logic        idAluSrc, idRegDst, idRegWrite, idMemRead, idMemWrite, idMemToReg;
  logic        memRegWrite;
  logic [4:0]  memWriteReg;
  logic [31:0] memAluRes;
  logic        wbRegWrite;
  logic [4:0]  wbWriteReg;
  logic [31:0] wbData;
  logic [31:0] input1, input2, exStoreData;
  logic [3:0]  aluCtr;
  logic        exValid;
  logic [4:0]  exWriteReg;
  logic        exRegWrite, exMemRead, exMemWrite, exMemToReg, loadUseStall;

  int unsigned tests = 0;
  int unsigned fails = 0;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .idValid(idValid),
    .idRsData(idRsData), .idRtData(idRtData), .idImm(idImm),
    .idRs(idRs), .idRt(idRt), .idRd(idRd), .idAluCtr(idAluCtr),
    .idAluSrc(idAluSrc), .idRegDst(idRegDst), .idRegWrite(idRegWrite),
    .idMemRead(idMemRead), .idMemWrite(idMemWrite), .idMemToReg(idMemToReg),
    .memRegWrite(memRegWrite), .memWriteReg(memWriteReg), .memAluRes(memAluRes),
    .wbRegWrite(wbRegWrite), .wbWriteReg(wbWriteReg), .wbData(wbData),
    .input1(input1), .input2(input2), .aluCtr(aluCtr), .exValid(exValid),
    .exWriteReg(exWriteReg), .exRegWrite(exRegWrite), .exMemRead(exMemRead),
    .exMemWrite(exMemWrite), .exMemToReg(exMemToReg), .exStoreData(exStoreData),
    .loadUseStall(loadUseStall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    idValid = 0; idRsData = '0; idRtData = '0; idImm = '0;
    idRs = '0; idRt = '0; idRd = '0; idAluCtr = '0;
    idAluSrc = 0; idRegDst = 0; idRegWrite = 0; idMemRead = 0;
    idMemWrite = 0; idMemToReg = 0;
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0;
    clear_id();
    memRegWrite = 0; memWriteReg = '0; memAluRes = '0;
    wbRegWrite = 0; wbWriteReg = '0; wbData = '0;
    #2;
    chk("rst_exValid", exValid, 0);
    chk("rst_aluCtr", aluCtr, 0);
    chk("rst_exWriteReg", exWriteReg, 0);
    chk("rst_input1", input1, 0);
    chk("rst_input2", input2, 0);
    chk("rst_exRegWrite", exRegWrite, 0);
    chk("rst_loadUse", loadUseStall, 0);

    // ID activity while reset held is ignored
    idValid = 1; idRsData = 32'h5; idRegWrite = 1; idAluCtr = 4'h3;
    step();
    chk("rst_hold_exValid", exValid, 0);
    chk("rst_hold_aluCtr", aluCtr, 0);

    // Plain capture
    reset = 0;
    clear_id();
    idValid = 1; idRsData = 32'd5; idRtData = 32'd3; idAluCtr = 4'b0110;
    idAluSrc = 0; idRegDst = 1; idRd = 5'd8; idRs = 5'd1; idRt = 5'd2; idRegWrite = 1;
    step();
    chk("cap_input1", input1, 32'd5);
    chk("cap_input2", input2, 32'd3);
    chk("cap_aluCtr", aluCtr, 4'b0110);
    chk("cap_exWriteReg", exWriteReg, 5'd8);
    chk("cap_exValid", exValid, 1);
    chk("cap_exRegWrite", exRegWrite, 1);

    // Immediate operand, destination rt
    idAluSrc = 1; idImm = 32'h1234; idRegDst = 0; idRt = 5'd7;
    step();
    chk("imm_input2", input2, 32'h1234);
    chk("imm_exWriteReg", exWriteReg, 5'd7);
    chk("imm_storeData", exStoreData, 32'd3);

    // Forwarding on rs=rt=9
    idRs = 5'd9; idRt = 5'd9; idRsData = 32'd1; idRtData = 32'd2;
    idAluSrc = 0; idRegDst = 1; idRd = 5'd10;
    step();
    idValid = 0;
    memRegWrite = 1; memWriteReg = 5'd9; memAluRes = 32'hAA;
    wbRegWrite = 1; wbWriteReg = 5'd9; wbData = 32'hBB;
    #1;
    chk("fwd_both_input1", input1, 32'hAA);
    chk("fwd_both_input2", input2, 32'hAA);
    chk("fwd_both_store", exStoreData, 32'hAA);
    memWriteReg = 5'd0;
    #1;
    chk("fwd_wb_input1", input1, 32'hBB);
    chk("fwd_wb_input2", input2, 32'hBB);
    wbRegWrite = 0;
    #1;
    chk("fwd_none_input1", input1, 32'd1);
    chk("fwd_none_input2", input2, 32'd2);

    // Register 0 is never forwarded
    idValid = 1; idRs = 5'd0; idRt = 5'd0; idRsData = 32'd0; idRtData = 32'h77;
    memRegWrite = 0; wbRegWrite = 0;
    step();
    memRegWrite = 1; memWriteReg = 5'd0; memAluRes = 32'hAA;
    wbRegWrite = 1; wbWriteReg = 5'd0; wbData = 32'hBB;
    #1;
    chk("r0_input1", input1, 32'd0);
    chk("r0_input2", input2, 32'h77);
    memRegWrite = 0; memWriteReg = '0; memAluRes = '0;
    wbRegWrite = 0; wbWriteReg = '0; wbData = '0;

    // Load-use: lw writes r4
    clear_id();
    idValid = 1; idMemRead = 1; idRegWrite = 1; idMemToReg = 1;
    idRegDst = 0; idRt = 5'd4; idRs = 5'd1;
    step();
    chk("lw_exMemRead", exMemRead, 1);
    chk("lw_exMemToReg", exMemToReg, 1);
    chk("lw_exWriteReg", exWriteReg, 5'd4);
    idMemRead = 0; idMemToReg = 0; idRs = 5'd4; idRt = 5'd5; idValid = 0;
    #1;
    chk("lu_idinvalid", loadUseStall, 0);
    idValid = 1;
    #1;
    chk("lu_rs_match", loadUseStall, 1);
    step();
    chk("lu_bubble_exValid", exValid, 0);
    chk("lu_bubble_exMemRead", exMemRead, 0);
    chk("lu_bubble_exRegWrite", exRegWrite, 0);
    chk("lu_bubble_clear", loadUseStall, 0);
    step();
    chk("lu_after_exValid", exValid, 1);

    // Load-use under stall: no bubble while stalled
    idMemRead = 1; idRt = 5'd4; idRs = 5'd1; idRegDst = 0;
    step();
    idMemRead = 0; idRs = 5'd6; idRt = 5'd4;
    stall = 1;
    #1;
    chk("lu_rt_match", loadUseStall, 1);
    step();
    chk("lu_stall_exValid", exValid, 1);
    chk("lu_stall_exMemRead", exMemRead, 1);
    stall = 0;
    step();
    chk("lu_unstall_bubble", exValid, 0);

    // Load into r0 never stalls
    idMemRead = 1; idRegDst = 0; idRt = 5'd0; idRs = 5'd0;
    step();
    idMemRead = 0;
    #1;
    chk("lu_r0_memRead", exMemRead, 1);
    chk("lu_r0_nostall", loadUseStall, 0);

    // Stall with a one-cycle WB forward
    clear_id();
    idValid = 1; idRs = 5'd3; idRsData = 32'h10; idRegWrite = 1; idAluCtr = 4'h2;
    step();
    chk("st_pre_input1", input1, 32'h10);
    stall = 1;
    wbRegWrite = 1; wbWriteReg = 5'd3; wbData = 32'h55;
    idRsData = 32'h99; idAluCtr = 4'hF;
    #1;
    chk("st_c1_input1", input1, 32'h55);
    step();
    wbRegWrite = 0; wbWriteReg = '0; wbData = '0;
    #1;
    chk("st_c2_input1", input1, 32'h55);
    chk("st_c2_aluCtr", aluCtr, 4'h2);
    step();
    chk("st_c3_input1", input1, 32'h55);
    step();
    chk("st_c4_input1", input1, 32'h55);
    chk("st_c4_exValid", exValid, 1);

    // Flush together with stall: flush wins
    flush = 1;
    step();
    chk("fs_exValid", exValid, 0);
    chk("fs_exRegWrite", exRegWrite, 0);
    flush = 0; stall = 0;
    step();
    chk("fl_pre_exValid", exValid, 1);
    flush = 1;
    step();
    chk("fl_exValid", exValid, 0);
    flush = 0;

    // Asynchronous reset mid-stall
    clear_id();
    idValid = 1; idMemRead = 1; idRegWrite = 1; idMemWrite = 1; idMemToReg = 1;
    idAluCtr = 4'h5; idRegDst = 1; idRd = 5'd7;
    step();
    chk("ar_pre_exValid", exValid, 1);
    chk("ar_pre_exMemWrite", exMemWrite, 1);
    idMemRead = 0; idMemWrite = 0; idMemToReg = 0; idRs = 5'd7;
    #1;
    chk("ar_pre_loadUse", loadUseStall, 1);
    stall = 1;
    #1;
    reset = 1;
    #1;
    chk("ar_exValid", exValid, 0);
    chk("ar_exRegWrite", exRegWrite, 0);
    chk("ar_exMemRead", exMemRead, 0);
    chk("ar_exMemWrite", exMemWrite, 0);
    chk("ar_exMemToReg", exMemToReg, 0);
    chk("ar_aluCtr", aluCtr, 0);
    chk("ar_exWriteReg", exWriteReg, 0);
    chk("ar_loadUse", loadUseStall, 0);
    chk("ar_input1", input1, 0);
    chk("ar_input2", input2, 0);
    #1;
    reset = 0; stall = 0;
    idRs = 5'd1; idRsData = 32'h21;
    step();
    chk("ar_post_exValid", exValid, 1);
    chk("ar_post_input1", input1, 32'h21);
    chk("ar_post_aluCtr", aluCtr, 4'h5);
    chk("ar_post_exWriteReg", exWriteReg, 5'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
